// File: rtl/clause_bin_mover.sv
// Moves one bin of clauses between the clause RAM and the core's clause array.
// LOAD streams RAM -> core via wr_carray strobes; UPDATE streams core -> RAM via rd_carray strobes.
module clause_bin_mover #(
    parameter int NUM_CLAUSES_A_BIN  = 8,
    parameter int NUM_VARS_A_BIN     = 8,
    parameter int WIDTH_BIN_ID       = 10,
    parameter int WIDTH_CLAUSES      = 16,
    parameter int ADDR_WIDTH_CLAUSES = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_load_i,
    input  logic                          start_update_i,
    input  logic [WIDTH_BIN_ID-1:0]       bin_num_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          ram_we_c_o,
    output logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_c_o,
    output logic [WIDTH_CLAUSES-1:0]      ram_din_c_o,
    input  logic [WIDTH_CLAUSES-1:0]      ram_dout_c_i,
    output logic [NUM_CLAUSES_A_BIN-1:0]  wr_carray_o,
    output logic [WIDTH_CLAUSES-1:0]      clause_o,
    output logic [NUM_CLAUSES_A_BIN-1:0]  rd_carray_o,
    input  logic [WIDTH_CLAUSES-1:0]      clause_i
);

    localparam int N     = NUM_CLAUSES_A_BIN;
    localparam int CNT_W = $clog2(N + 1);
    localparam int AW    = ADDR_WIDTH_CLAUSES;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_UPDATE
    } state_t;

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]  base_q, base_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           we_q, we_d;
    logic [N-1:0]   wr_q, wr_d;
    logic [N-1:0]   rd_q, rd_d;

    logic [AW-1:0]  start_base;
    logic           cnt_fin;
    logic           cnt_in_bin;
    logic           cnt_before_last;

    // Base address wraps modulo the RAM depth; no range check by design.
    assign start_base      = AW'(32'(bin_num_i) * 32'(N));
    assign cnt_fin         = (cnt_q == CNT_W'(N));
    assign cnt_in_bin      = (cnt_q < CNT_W'(N));
    assign cnt_before_last = (cnt_q < CNT_W'(N - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        wr_d    = '0;
        rd_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (start_load_i) begin
                    state_d = S_LOAD;
                    base_d  = start_base;
                    addr_d  = start_base;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (start_update_i) begin
                    state_d = S_UPDATE;
                    base_d  = start_base;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    rd_d    = N'(1);
                end
            end
            S_LOAD: begin
                cnt_d = cnt_q + CNT_W'(1);
                // RAM read data lags the address by one cycle, so the strobe trails it.
                if (cnt_in_bin)
                    wr_d = N'(1) << cnt_q;
                if (cnt_before_last)
                    addr_d = base_q + AW'(cnt_q) + AW'(1);
                if (cnt_fin) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_UPDATE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_before_last)
                    rd_d = N'(1) << (cnt_q + CNT_W'(1));
                // Core data lags rd_carray by one cycle; the write lands on that cycle.
                if (cnt_in_bin) begin
                    we_d   = 1'b1;
                    addr_d = base_q + AW'(cnt_q);
                end
                if (cnt_fin) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign ram_we_c_o   = we_q;
    assign ram_addr_c_o = addr_q;
    assign wr_carray_o  = wr_q;
    assign rd_carray_o  = rd_q;
    // Data buses are forwarded in the strobe cycle and forced to zero otherwise.
    assign clause_o     = (|wr_q) ? ram_dout_c_i : '0;
    assign ram_din_c_o  = we_q ? clause_i : '0;

endmodule

// File: tb/tb_clause_bin_mover.sv
// Directed bench for clause_bin_mover with a synchronous clause RAM and core array model.
module tb_clause_bin_mover;

    localparam int N  = 8;
    localparam int AW = 9;

    logic          clk;
    logic          rst;
    logic          start_load_i;
    logic          start_update_i;
    logic [9:0]    bin_num_i;
    logic          busy_o;
    logic          done_o;
    logic          ram_we_c_o;
    logic [AW-1:0] ram_addr_c_o;
    logic [15:0]   ram_din_c_o;
    logic [15:0]   ram_dout_c_i;
    logic [N-1:0]  wr_carray_o;
    logic [15:0]   clause_o;
    logic [N-1:0]  rd_carray_o;
    logic [15:0]   clause_i;

    logic [15:0]   mem [512];
    int nvec;
    int nmis;

    clause_bin_mover dut (
        .clk            (clk),
        .rst            (rst),
        .start_load_i   (start_load_i),
        .start_update_i (start_update_i),
        .bin_num_i      (bin_num_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .ram_we_c_o     (ram_we_c_o),
        .ram_addr_c_o   (ram_addr_c_o),
        .ram_din_c_o    (ram_din_c_o),
        .ram_dout_c_i   (ram_dout_c_i),
        .wr_carray_o    (wr_carray_o),
        .clause_o       (clause_o),
        .rd_carray_o    (rd_carray_o),
        .clause_i       (clause_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we_c_o)
            mem[ram_addr_c_o] <= ram_din_c_o;
        ram_dout_c_i <= mem[ram_addr_c_o];
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (rd_carray_o[i])
                clause_i <= 16'hA5A0 + 16'(i);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy"},  32'(busy_o), 0);
        chk({tag, " done"},  32'(done_o), 0);
        chk({tag, " we"},    32'(ram_we_c_o), 0);
        chk({tag, " addr"},  32'(ram_addr_c_o), 0);
        chk({tag, " din"},   32'(ram_din_c_o), 0);
        chk({tag, " wr"},    32'(wr_carray_o), 0);
        chk({tag, " clause"}, 32'(clause_o), 0);
        chk({tag, " rd"},    32'(rd_carray_o), 0);
    endtask

    task automatic check_cycle(input string name, input int j, input bit ld, input int base);
        logic [31:0] e_wr, e_rd, e_we, e_clause, e_din;
        int k;
        string t;
        t = $sformatf("%s j%0d", name, j);
        chk({t, " busy"}, 32'(busy_o), (j >= 1 && j <= N + 1) ? 1 : 0);
        chk({t, " done"}, 32'(done_o), (j == N + 2) ? 1 : 0);
        e_wr = 0; e_rd = 0; e_we = 0; e_clause = 0; e_din = 0;
        if (ld) begin
            if (j >= 2 && j <= N + 1) begin
                e_wr     = 32'(1) << (j - 2);
                e_clause = 32'h0100 + 32'((base + j - 2) % 512);
            end
            k = (j - 1 < N - 1) ? j - 1 : N - 1;
            chk({t, " addr"}, 32'(ram_addr_c_o), 32'((base + k) % 512));
        end else begin
            if (j >= 1 && j <= N)
                e_rd = 32'(1) << (j - 1);
            if (j >= 2 && j <= N + 1) begin
                e_we  = 1;
                e_din = 32'h0000A5A0 + 32'(j - 2);
            end
            if (j >= 2) begin
                k = (j - 2 < N - 1) ? j - 2 : N - 1;
                chk({t, " addr"}, 32'(ram_addr_c_o), 32'((base + k) % 512));
            end
        end
        chk({t, " wr"},     32'(wr_carray_o), e_wr);
        chk({t, " clause"}, 32'(clause_o), e_clause);
        chk({t, " rd"},     32'(rd_carray_o), e_rd);
        chk({t, " we"},     32'(ram_we_c_o), e_we);
        chk({t, " din"},    32'(ram_din_c_o), e_din);
    endtask

    // inj_j: cycle index at which a stray start_update is pulsed; rst_j: cycle of reset
    task automatic run_op(input string name, input bit ld, input bit up, input int bin,
                          input int inj_j, input int rst_j);
        int base;
        base = (bin * N) % 512;
        @(negedge clk);
        start_load_i   = ld;
        start_update_i = up;
        bin_num_i      = 10'(bin);
        @(negedge clk);
        start_load_i   = 1'b0;
        start_update_i = 1'b0;
        for (int j = 1; j <= N + 3; j++) begin
            if (j == rst_j) begin
                rst = 1'b0;
                #1;
                chk_idle_zero({name, " in-reset"});
                repeat (2) begin
                    @(negedge clk);
                    chk({name, " rst we"},   32'(ram_we_c_o), 0);
                    chk({name, " rst busy"}, 32'(busy_o), 0);
                end
                rst = 1'b1;
                return;
            end
            check_cycle(name, j, ld, base);
            start_update_i = (j == inj_j);
            @(negedge clk);
        end
        start_update_i = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        rst            = 1'b0;
        start_load_i   = 1'b0;
        start_update_i = 1'b0;
        bin_num_i      = '0;
        for (int a = 0; a < 512; a++)
            mem[a] = 16'h0100 + 16'(a);
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b1;

        run_op("load bin0", 1'b1, 1'b0, 0, 0, 0);

        run_op("update bin3", 1'b0, 1'b1, 3, 0, 0);
        for (int k = 0; k < N; k++)
            chk($sformatf("ram[%0d]", 24 + k), 32'(mem[24 + k]), 32'h0000A5A0 + 32'(k));

        run_op("both bin1", 1'b1, 1'b1, 1, 0, 0);
        for (int k = 0; k < N; k++)
            chk($sformatf("bin1 ram[%0d]", 8 + k), 32'(mem[8 + k]), 32'h0108 + 32'(k));

        run_op("load+upd bin2", 1'b1, 1'b0, 2, 4, 0);
        chk("bin2 ram[16]", 32'(mem[16]), 32'h0110);

        run_op("wrap bin64", 1'b1, 1'b0, 64, 0, 0);

        run_op("reset upd bin5", 1'b0, 1'b1, 5, 0, 5);
        chk("bin5 ram[40]", 32'(mem[40]), 32'h0000A5A0);
        chk("bin5 ram[42]", 32'(mem[42]), 32'h0000A5A2);
        chk("bin5 ram[43]", 32'(mem[43]), 32'h012B);
        chk("bin5 ram[47]", 32'(mem[47]), 32'h012F);

        run_op("post-rst load bin6", 1'b1, 1'b0, 6, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
